neopixel_stream_tx: RTL and testbench
=====================================

Name: neopixel_stream_tx

Overview:
- Parametrised successor to the single-bit pixel writer. Serialises whole WS2812-style pixel words, MSB first, onto one data line, with cycle-accurate T0H/T1H/bit-period timing taken from parameters.
- A one-word holding buffer and a valid/ready handshake let upstream logic stream a frame back-to-back.
- A frame ends with a parametrised latch (reset) low period.
- Sits between the frame/pixel sequencer and the PMod output pin.

Parameters:
- WORD_BITS, 24, bits per pixel word (GRB = 24, GRBW = 32); legal range 1..64.
- T0H_CYC, 4, high time of a '0' bit, in CLK cycles.
- T1H_CYC, 8, high time of a '1' bit, in CLK cycles.
- TBIT_CYC, 15, total bit period, in CLK cycles.
- TRST_CYC, 960, latch low period (80 us at 12 MHz), in CLK cycles.
- Constraint: 1 <= T0H_CYC < T1H_CYC < TBIT_CYC, and TRST_CYC >= 1. Violations fail elaboration.

Ports:
- CLK  in  1  system clock.
- RSTN  in  1  asynchronous, active-low reset.
- in_data  in  WORD_BITS  pixel word, MSB transmitted first.
- in_valid  in  1  in_data/in_last valid.
- in_last  in  1  word is the last of the frame; latch follows it.
- in_ready  out  1  holding buffer empty; word accepted when in_valid && in_ready at a CLK edge.
- d_out  out  1  registered serial line to pixels.
- busy  out  1  high in any state other than IDLE, or while the buffer is full.
- frame_done  out  1  one-cycle pulse at the end of the latch period.
- underrun  out  1  one-cycle pulse when a mid-frame gap reached TRST_CYC.

Behaviour:
- Reset (RSTN low, asynchronous):
  - d_out=0, busy=0, frame_done=0, underrun=0, in_ready=1.
  - Buffer emptied, state=IDLE, all counters 0.
  - A reset mid-bit truncates the pulse immediately. Any partial word is discarded.
- Holding buffer:
  - Stores one data+last pair. in_ready = !buf_full, registered.
  - Accept and unload can happen on the same edge. The buffer then stays full with the new word.
- Bit timer:
  - cnt runs 0..TBIT_CYC-1.
  - d_out=1 while cnt < (bit ? T1H_CYC : T0H_CYC); otherwise 0.
  - Every bit lasts exactly TBIT_CYC cycles.
- State machine (IDLE, SEND, GAP, LATCH):
  - IDLE: d_out=0. If buf_full, load the shifter from the buffer, clear the buffer, go to SEND with cnt=0.
    - Latency: accept at edge k -> load at edge k+1 -> d_out=1 from edge k+2.
  - SEND: shift out WORD_BITS bits. At cnt=TBIT_CYC-1 of the final bit, by priority:
    - (a) word was not last and buffer full: load the next word, stay in SEND, no idle cycle between words;
    - (b) word was last: go to LATCH, gcnt=0;
    - (c) otherwise go to GAP, gcnt=0.
  - GAP: d_out=0, gcnt increments.
    - If buf_full: load and return to SEND (gap shorter than latch; pixels keep shifting).
    - If gcnt reaches TRST_CYC-1 with the buffer empty: pulse underrun, go to IDLE. The chain has latched.
  - LATCH: d_out=0 for exactly TRST_CYC cycles. On the last cycle, pulse frame_done and go to IDLE.
    - Words may be accepted into the buffer during LATCH, but are not sent before IDLE.
- Widths: bit index is $clog2(WORD_BITS+1) bits. cnt is $clog2(TBIT_CYC) bits. gcnt is $clog2(TRST_CYC+1) bits.
- Counters never wrap: they are cleared on each state/bit transition.
- in_valid with in_ready low: the word is held off upstream. The block does not drop it.

Decomposition:
- Shared package neopixel_pkg holds:
  - the state enum (IDLE/SEND/GAP/LATCH);
  - default timing constants for 12 MHz (T0H/T1H/TBIT/TRST);
  - WORD_BITS presets (GRB=24, GRBW=32).
- Sub-module neopixel_bit_timer holds the cnt counter and the high/low compare. Inputs: start, bit. Outputs: level, bit_end.

Test Plan:
- Single word 24'hA50000, in_last=1 -> first bit high 8 cycles/low 7, second high 4/low 11; 24 bits = 360 cycles; then d_out=0 for 960 cycles; frame_done pulses once; busy falls the next cycle.
- Three words streamed with in_valid held high, last on the third -> no idle cycle between words (1080 contiguous bit cycles); in_ready low while the buffer is full; a single latch follows.
- Word 1 not last, word 2 presented 100 cycles after word 1 ends -> GAP of 100 low cycles, then SEND resumes; no underrun pulse.
- Word not last, no follow-up -> underrun pulses 960 cycles after the last bit ends; state returns to IDLE; frame_done stays 0.
- RSTN asserted 3 cycles into a '1' bit high phase -> d_out=0 asynchronously; after release, in_ready=1, busy=0, and a fresh word transmits correctly from bit 0.
- WORD_BITS=32, word 32'h00000001, last -> 31 '0' pulses then one '1' pulse; total 480 cycles before the latch.

Source files
------------

// File: rtl/neopixel_pkg.sv
// -----------------------------------------------------------------------------
// neopixel_pkg
// Shared definitions for the WS2812-style pixel stream transmitter:
//   - np_state_e   : transmitter state encoding (IDLE/SEND/GAP/LATCH)
//   - NP_*_12MHZ   : default bit/latch timing for a 12 MHz clock
//   - NP_WORD_*    : pixel word width presets (GRB, GRBW)
//   - np_params_ok : elaboration-time legality check of the timing set
// -----------------------------------------------------------------------------
package neopixel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_GAP   = 2'd2,
    ST_LATCH = 2'd3
  } np_state_e;

  // Timing at 12 MHz: 0-bit high 333 ns, 1-bit high 667 ns, 1.25 us bit, 80 us latch
  localparam int unsigned NP_T0H_12MHZ  = 32'd4;
  localparam int unsigned NP_T1H_12MHZ  = 32'd8;
  localparam int unsigned NP_TBIT_12MHZ = 32'd15;
  localparam int unsigned NP_TRST_12MHZ = 32'd960;

  localparam int unsigned NP_WORD_GRB   = 32'd24;
  localparam int unsigned NP_WORD_GRBW  = 32'd32;

  // True when the word width and timing set describe a realisable waveform
  function automatic logic np_params_ok(
    input int unsigned word_bits,
    input int unsigned t0h,
    input int unsigned t1h,
    input int unsigned tbit,
    input int unsigned trst
  );
    return (word_bits >= 32'd1) && (word_bits <= 32'd64) &&
           (t0h >= 32'd1) && (t0h < t1h) && (t1h < tbit) &&
           (trst >= 32'd1);
  endfunction

endpackage

// File: rtl/neopixel_stream_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// neopixel_bit_timer
// Times one serial bit: a counter runs 0..TBIT_CYC-1 while 'run' is high and
// the line level is high for the first T1H_CYC (bit=1) or T0H_CYC (bit=0)
// cycles of the period.
// Ports:
//   CLK, RSTN : clock, asynchronous active-low reset
//   start     : restart the bit period at count 0 (word load)
//   run       : count this cycle (transmitter is in SEND)
//   bit_val   : value of the bit currently being sent
//   level     : unregistered line level for this cycle
//   bit_end   : last cycle of the current bit period
// -----------------------------------------------------------------------------
module neopixel_bit_timer
  import neopixel_pkg::*;
#(
  parameter int unsigned T0H_CYC  = NP_T0H_12MHZ,
  parameter int unsigned T1H_CYC  = NP_T1H_12MHZ,
  parameter int unsigned TBIT_CYC = NP_TBIT_12MHZ
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic start,
  input  logic run,
  input  logic bit_val,
  output logic level,
  output logic bit_end
);

  localparam int unsigned CNT_W = $clog2(TBIT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TBIT_CYC - 32'd1);
  localparam logic [CNT_W-1:0] T0H_LIM  = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] T1H_LIM  = CNT_W'(T1H_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] hi_lim_s;

  // High/low compare and end-of-bit detect for the current count
  always_comb begin
    hi_lim_s = '0;
    if (bit_val) begin
      hi_lim_s = T1H_LIM;
    end else begin
      hi_lim_s = T0H_LIM;
    end
    level   = run && (cnt_r < hi_lim_s);
    bit_end = run && (cnt_r == CNT_LAST);
  end

  // Bit-period counter; cleared rather than wrapped at every bit boundary
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_r <= '0;
    end else if (start || !run || bit_end) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

endmodule

// File: rtl/neopixel_stream_tx.sv
// -----------------------------------------------------------------------------
// neopixel_stream_tx
// Serialises WS2812-style pixel words (MSB first) onto one data line with a
// one-word holding buffer so upstream can stream a frame back-to-back. A word
// flagged last is followed by a TRST_CYC latch low period.
// Ports:
//   CLK, RSTN  : clock, asynchronous active-low reset
//   in_data    : pixel word, MSB transmitted first
//   in_valid   : in_data/in_last valid
//   in_last    : word is the last of the frame
//   in_ready   : holding buffer empty (accept on in_valid && in_ready)
//   d_out      : registered serial line
//   busy       : transmitter not idle or buffer occupied
//   frame_done : one-cycle pulse at the end of the latch period
//   underrun   : one-cycle pulse when a mid-frame gap reached TRST_CYC
// -----------------------------------------------------------------------------
module neopixel_stream_tx
  import neopixel_pkg::*;
#(
  parameter int unsigned WORD_BITS = NP_WORD_GRB,
  parameter int unsigned T0H_CYC   = NP_T0H_12MHZ,
  parameter int unsigned T1H_CYC   = NP_T1H_12MHZ,
  parameter int unsigned TBIT_CYC  = NP_TBIT_12MHZ,
  parameter int unsigned TRST_CYC  = NP_TRST_12MHZ
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [WORD_BITS-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 d_out,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 underrun
);

  if (!np_params_ok(WORD_BITS, T0H_CYC, T1H_CYC, TBIT_CYC, TRST_CYC)) begin : g_bad_params
    $error("neopixel_stream_tx: illegal WORD_BITS or timing parameters");
  end

  localparam int unsigned IDX_W  = $clog2(WORD_BITS + 32'd1);
  localparam int unsigned GCNT_W = $clog2(TRST_CYC + 32'd1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORD_BITS - 32'd1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1'b1);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(TRST_CYC - 32'd1);
  localparam logic [GCNT_W-1:0] GCNT_ONE  = GCNT_W'(1'b1);

  np_state_e            state_r;
  np_state_e            state_s;

  logic                 buf_full_r;
  logic [WORD_BITS-1:0] buf_data_r;
  logic                 buf_last_r;
  logic                 buf_full_s;

  logic [WORD_BITS-1:0] shift_r;
  logic                 word_last_r;
  logic [IDX_W-1:0]     bit_idx_r;
  logic [GCNT_W-1:0]    gcnt_r;

  logic                 in_ready_r;
  logic                 d_out_r;
  logic                 busy_r;
  logic                 frame_done_r;
  logic                 underrun_r;

  logic                 accept_s;
  logic                 load_s;
  logic                 shift_s;
  logic                 gcnt_inc_s;
  logic                 done_s;
  logic                 under_s;
  logic                 run_s;
  logic                 level_s;
  logic                 bit_end_s;
  logic                 last_bit_s;
  logic                 gcnt_end_s;

  assign in_ready   = in_ready_r;
  assign d_out      = d_out_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign underrun   = underrun_r;

  neopixel_bit_timer #(
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .TBIT_CYC (TBIT_CYC)
  ) u_bit_timer (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .start   (load_s),
    .run     (run_s),
    .bit_val (shift_r[WORD_BITS-1]),
    .level   (level_s),
    .bit_end (bit_end_s)
  );

  // Handshake, word-position and gap-counter status decode
  always_comb begin
    accept_s   = in_valid && in_ready_r;
    run_s      = (state_r == ST_SEND);
    last_bit_s = (bit_idx_r == IDX_LAST);
    gcnt_end_s = (gcnt_r == GCNT_LAST);
    // Buffer occupancy after this edge: a new word wins over an unload
    buf_full_s = accept_s || (buf_full_r && !load_s);
  end

  // Next-state and control decode
  always_comb begin
    state_s    = state_r;
    load_s     = 1'b0;
    shift_s    = 1'b0;
    gcnt_inc_s = 1'b0;
    done_s     = 1'b0;
    under_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (buf_full_r) begin
          load_s  = 1'b1;
          state_s = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (bit_end_s && last_bit_s) begin
          if (!word_last_r && buf_full_r) begin
            // Chain the next word with no idle cycle between words
            load_s  = 1'b1;
            state_s = ST_SEND;
          end else if (word_last_r) begin
            state_s = ST_LATCH;
          end else begin
            state_s = ST_GAP;
          end
        end else if (bit_end_s) begin
          shift_s = 1'b1;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_GAP: begin
        if (buf_full_r) begin
          // Gap stayed shorter than a latch: pixels keep shifting
          load_s  = 1'b1;
          state_s = ST_SEND;
        end else if (gcnt_end_s) begin
          under_s = 1'b1;
          state_s = ST_IDLE;
        end else begin
          gcnt_inc_s = 1'b1;
        end
      end
      ST_LATCH: begin
        if (gcnt_end_s) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          gcnt_inc_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // One-word holding buffer
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      buf_full_r <= 1'b0;
      buf_data_r <= '0;
      buf_last_r <= 1'b0;
    end else if (accept_s) begin
      buf_full_r <= 1'b1;
      buf_data_r <= in_data;
      buf_last_r <= in_last;
    end else if (load_s) begin
      buf_full_r <= 1'b0;
    end else begin
      buf_full_r <= buf_full_r;
    end
  end

  // Output shifter, bit index and last-word flag of the word on the line
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      shift_r     <= '0;
      word_last_r <= 1'b0;
      bit_idx_r   <= '0;
    end else if (load_s) begin
      shift_r     <= buf_data_r;
      word_last_r <= buf_last_r;
      bit_idx_r   <= '0;
    end else if (shift_s) begin
      shift_r     <= shift_r << 1;
      bit_idx_r   <= bit_idx_r + IDX_ONE;
    end else begin
      shift_r     <= shift_r;
    end
  end

  // Gap/latch counter; any cycle that does not count clears it
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      gcnt_r <= '0;
    end else if (gcnt_inc_s) begin
      gcnt_r <= gcnt_r + GCNT_ONE;
    end else begin
      gcnt_r <= '0;
    end
  end

  // Registered outputs
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      in_ready_r   <= 1'b1;
      d_out_r      <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      in_ready_r   <= !buf_full_s;
      d_out_r      <= level_s;
      busy_r       <= (state_r != ST_IDLE) || buf_full_r;
      frame_done_r <= done_s;
      underrun_r   <= under_s;
    end
  end

endmodule

// File: tb/tb_neopixel_stream_tx.sv
// Scoreboard bench: the driver pushes each accepted word into exp_q, and a
// monitor decodes d_out back into words from pulse widths and checks bit
// period, data, and the exact cycle of the frame_done / underrun pulse.
module tb_neopixel_stream_tx;
  localparam int WB = 24, T0H = 4, T1H = 8, TBIT = 15, TRST = 960;

  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  logic [WB-1:0] in_data;
  logic in_valid, in_last, in_ready, d_out, busy, frame_done, underrun;
  logic [31:0] in_data2;
  logic in_valid2, in_last2, in_ready2, d2, busy2, fd2, un2;

  always #5 CLK = ~CLK;

  neopixel_stream_tx #(.WORD_BITS(WB), .T0H_CYC(T0H), .T1H_CYC(T1H),
                       .TBIT_CYC(TBIT), .TRST_CYC(TRST)) dut (
    .CLK(CLK), .RSTN(RSTN), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .d_out(d_out), .busy(busy),
    .frame_done(frame_done), .underrun(underrun));

  neopixel_stream_tx #(.WORD_BITS(32), .T0H_CYC(T0H), .T1H_CYC(T1H),
                       .TBIT_CYC(TBIT), .TRST_CYC(TRST)) dut32 (
    .CLK(CLK), .RSTN(RSTN), .in_data(in_data2), .in_valid(in_valid2),
    .in_last(in_last2), .in_ready(in_ready2), .d_out(d2), .busy(busy2),
    .frame_done(fd2), .underrun(un2));

  typedef struct {logic [WB-1:0] data; logic last;} exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0;
  int ncyc = 0, hi_len = 0, rise_cyc = 0, bit_cnt = 0, pend_cyc = 0;
  int last_gap = 0, contig_cnt = 0, word_cnt = 0, under_cnt = 0, frame_cnt = 0;
  logic prev_d = 1'b0, pend_valid = 1'b0, pend_last = 1'b0, have_rise = 1'b0;
  logic [WB-1:0] acc = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: decode the line and check latch/underrun pulse timing
  always @(negedge CLK) begin
    exp_t e;
    if (!RSTN) begin
      exp_q.delete();
      prev_d = 1'b0; pend_valid = 1'b0; bit_cnt = 0; hi_len = 0; have_rise = 1'b0;
    end else begin
      ncyc++;
      if (d_out && !prev_d) begin
        if (pend_valid) begin
          if (pend_last) chk("rise_in_latch", ncyc, pend_cyc + 2);
          pend_valid = 1'b0;
        end
        if (have_rise) begin
          if (bit_cnt != 0) chk("bit_period", ncyc - rise_cyc, TBIT);
          else begin
            last_gap = ncyc - rise_cyc;
            if (last_gap == TBIT) contig_cnt++;
          end
        end
        rise_cyc = ncyc; have_rise = 1'b1; hi_len = 1;
      end else if (d_out) begin
        hi_len++;
      end
      if (pend_valid && ncyc == pend_cyc) begin
        chk("frame_done_at_end", frame_done, pend_last);
        chk("underrun_at_end", underrun, !pend_last);
        if (frame_done) frame_cnt++;
        if (underrun) under_cnt++;
        pend_valid = 1'b0;
      end else if (frame_done || underrun) begin
        chk("stray_pulse", {frame_done, underrun}, 2'b00);
      end
      if (!d_out && prev_d) begin
        chk("high_len_legal", (hi_len == T0H) || (hi_len == T1H), 1'b1);
        acc = {acc[WB-2:0], (hi_len == T1H)};
        bit_cnt++;
        if (bit_cnt == WB) begin
          bit_cnt = 0; word_cnt++;
          if (exp_q.size() == 0) chk("word_expected", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk("word_data", acc, e.data);
            pend_valid = 1'b1; pend_last = e.last;
            pend_cyc = rise_cyc + TBIT - 1 + TRST;
          end
        end
      end
      prev_d = d_out;
    end
  end

  // Driver: called at a negedge, returns at the negedge after acceptance
  task automatic send_word(input logic [WB-1:0] d, input logic l);
    exp_t e;
    int w = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    while (!in_ready && w < 5000) begin @(negedge CLK); w++; end
    chk("send_no_timeout", w < 5000, 1'b1);
    e.data = d; e.last = l;
    exp_q.push_back(e);
    @(negedge CLK);
    in_valid = 1'b0;
    chk("ready_low_when_full", in_ready, 1'b0);
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp_q.size() != 0 || pend_valid || busy) && w < 20000) begin
      @(negedge CLK); w++;
    end
    chk("drain_no_timeout", w < 20000, 1'b1);
  endtask

  initial begin
    int w, c0, f0, u0, wc, hi, lo, el;
    logic l;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    in_valid2 = 1'b0; in_last2 = 1'b0; in_data2 = '0;
    repeat (3) @(negedge CLK);
    chk("rst_d_out", d_out, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pulses", {frame_done, underrun}, 2'b00);
    chk("rst_ready32", in_ready2, 1'b1);
    RSTN = 1'b1;
    @(negedge CLK);

    // Single last word, then latch; busy drops the cycle after frame_done
    f0 = frame_cnt;
    send_word(24'hA50000, 1'b1);
    w = 0;
    while (!frame_done && w < 3000) begin @(negedge CLK); w++; end
    chk("t1_frame_done_seen", frame_done, 1'b1);
    chk("t1_busy_at_done", busy, 1'b1);
    @(negedge CLK);
    chk("t1_busy_after", busy, 1'b0);
    chk("t1_done_one_cycle", frame_done, 1'b0);
    wait_drain();
    chk("t1_frames", frame_cnt, f0 + 1);

    // Three words streamed back to back, one latch
    c0 = contig_cnt; f0 = frame_cnt;
    send_word(24'h123456, 1'b0);
    send_word(24'hFEDCBA, 1'b0);
    send_word(24'h0F0F0F, 1'b1);
    wait_drain();
    chk("t2_contiguous", contig_cnt, c0 + 2);
    chk("t2_frames", frame_cnt, f0 + 1);

    // Short gap between words of one frame: no underrun
    u0 = under_cnt; wc = word_cnt;
    send_word(24'h800001, 1'b0);
    w = 0;
    while (word_cnt == wc && w < 2000) begin @(negedge CLK); w++; end
    repeat (100) @(negedge CLK);
    send_word(24'h00FF00, 1'b1);
    wait_drain();
    chk("t3_gap_len", (last_gap > 100) && (last_gap < 120), 1'b1);
    chk("t3_no_underrun", under_cnt, u0);

    // Non-last word with no follow-up: underrun, no frame_done
    u0 = under_cnt; f0 = frame_cnt;
    send_word(24'h5A5A5A, 1'b0);
    wait_drain();
    chk("t4_underrun", under_cnt, u0 + 1);
    chk("t4_no_frame", frame_cnt, f0);

    // Reset during a '1' high phase, then a fresh word
    send_word(24'hFFFFFF, 1'b1);
    w = 0;
    while (!d_out && w < 100) begin @(negedge CLK); w++; end
    repeat (2) @(negedge CLK);
    #7 RSTN = 1'b0;
    #1 chk("t5_async_d_out", d_out, 1'b0);
    chk("t5_rst_ready", in_ready, 1'b1);
    chk("t5_rst_busy", busy, 1'b0);
    repeat (3) @(negedge CLK);
    #2 RSTN = 1'b1;
    @(negedge CLK);
    chk("t5_ready_after", in_ready, 1'b1);
    chk("t5_busy_after", busy, 1'b0);
    send_word(24'hC3A501, 1'b1);
    wait_drain();

    // Randomised frames with mixed gaps
    for (int i = 0; i < 16; i++) begin
      l = ($urandom_range(0, 3) == 0) || (i == 15);
      send_word(WB'($urandom), l);
      w = $urandom_range(0, 9);
      if (w >= 9) begin
        wait_drain();
        repeat ($urandom_range(1, 50)) @(negedge CLK);
      end else if (w >= 6) begin
        repeat ($urandom_range(1, 150)) @(negedge CLK);
      end
    end
    wait_drain();

    // 32-bit word 0x00000001: 31 short pulses, one long, 480 cycles total
    in_data2 = 32'h0000_0001; in_last2 = 1'b1; in_valid2 = 1'b1;
    @(negedge CLK);
    in_valid2 = 1'b0;
    w = 0;
    while (!d2 && w < 100) begin @(negedge CLK); w++; end
    el = 0;
    for (int b = 0; b < 32; b++) begin
      hi = 0; lo = 0;
      while (d2 && hi < TBIT) begin hi++; @(negedge CLK); end
      while (!d2 && hi + lo < TBIT) begin lo++; @(negedge CLK); end
      chk("w32_high_len", hi, (b == 31) ? T1H : T0H);
      el += hi + lo;
    end
    chk("w32_word_len", el, 32 * TBIT);
    w = 0;
    while (!fd2 && w < 2000) begin @(negedge CLK); w++; end
    chk("w32_frame_done_time", el + w, 32 * TBIT - 1 + TRST);
    chk("w32_no_underrun", un2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
